// File: rtl/serial_demux16.sv
// serial_demux16: serial-to-parallel receiver for a 16-to-1 bit-select mux stream.
// The s output walks the word index and can drive the transmitter mux select
// directly. Each strobed bit lands at w[s], and w[0] is the first bit received.
// A completed word is published on w together with a one-cycle valid pulse.
module serial_demux16 #(
    parameter int WIDTH = 16,   // bits per frame, must equal 2**SEL_W
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             f,
    output logic [SEL_W-1:0] s,
    output logic [0:WIDTH-1] w,
    output logic             valid,
    output logic             busy,
    output logic             abort
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [0:WIDTH-1] shadow;
    logic [0:WIDTH-1] shadow_next;
    logic             capture;

    // A bit is taken only in SHIFT on a strobe that is not overridden by start.
    assign capture = (state == SHIFT) && en && !start;

    // Per-bit next value of the shadow word.
    // Any start clears the whole word. Otherwise only the bit addressed by s
    // can load on a capture, and every other bit holds.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shadow
            assign shadow_next[gi] = start ? 1'b0 :
                                     (capture && (s == SEL_W'(gi))) ? f :
                                     shadow[gi];
        end
    endgenerate

    // Frame control FSM with registered outputs.
    // valid and abort are cleared on every cycle by default, so each one is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            shadow <= '0;
            w      <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            abort  <= 1'b0;
        end else begin
            shadow <= shadow_next;
            valid  <= 1'b0;
            abort  <= 1'b0;
            case (state)
                IDLE: begin
                    // en is ignored here. The start cycle itself captures nothing.
                    if (start) begin
                        state <= SHIFT;
                        s     <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        // A restart discards the partial frame and leaves w untouched.
                        s     <= '0;
                        abort <= 1'b1;
                    end else if (en) begin
                        if (s == LAST) begin
                            // shadow_next already holds the final bit, so w gets the full word.
                            w     <= shadow_next;
                            s     <= '0;
                            valid <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start here opens the next frame immediately and raises no abort.
                    if (start) begin
                        state <= SHIFT;
                        s     <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_demux16.sv
// Self-checking bench for serial_demux16.
// It runs directed frames, gapped and back-to-back frames, a mux loopback,
// a restart, asynchronous resets and a randomized tail, all checked against
// a frame-level reference model that keeps the received bits in a queue.
module tb_serial_demux16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        en;
    logic        f_drv;
    logic        f;
    logic        lb_mode;
    logic [0:15] lb_word;
    logic [3:0]  s;
    logic [0:15] w;
    logic        valid;
    logic        busy;
    logic        abort;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    // m_active is high while a frame is open. m_bits holds the bits captured so far.
    bit          m_active;
    bit          m_bits[$];
    logic [0:15] m_w;
    bit          exp_valid;
    bit          exp_abort;

    always #5 clk = ~clk;

    // 16-to-1 transmitter mux, used only in loopback mode.
    assign f = lb_mode ? lb_word[s] : f_drv;

    serial_demux16 #(.WIDTH(16), .SEL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .en    (en),
        .f     (f),
        .s     (s),
        .w     (w),
        .valid (valid),
        .busy  (busy),
        .abort (abort)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_bits.delete();
        m_w       = '0;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".s"},     s,      m_bits.size());
        check({where, ".busy"},  busy,   m_active);
        check({where, ".valid"}, valid,  exp_valid);
        check({where, ".abort"}, abort,  exp_abort);
        check({where, ".w"},     w,      m_w);
    endtask

    // One clock cycle.
    // Inputs are driven after the falling edge and the model is advanced.
    // The outputs are checked 1 time unit after the rising edge.
    task automatic cycle(input bit st, input bit e, input bit fb, input string where);
        bit fm;
        @(negedge clk);
        start = st;
        en    = e;
        f_drv = fb;
        fm = lb_mode ? lb_word[m_bits.size()] : fb;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (st) begin
            if (m_active) exp_abort = 1'b1;
            m_active = 1'b1;
            m_bits.delete();
        end else if (m_active && e) begin
            m_bits.push_back(fm);
            if (m_bits.size() == 16) begin
                for (int i = 0; i < 16; i++) m_w[i] = m_bits[i];
                exp_valid = 1'b1;
                m_active  = 1'b0;
                m_bits.delete();
            end
        end
        @(posedge clk);
        #1;
        check_outputs(where);
        $display("cyc start=%0b en=%0b f=%0b -> s=%0d busy=%0b valid=%0b abort=%0b w=%h",
                 st, e, f, s, busy, valid, abort, w);
    endtask

    // Assert reset between clock edges and check the outputs before any edge occurs.
    task automatic async_reset(input string where);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(where);
        $display("async reset at %0t -> s=%0d w=%h", $time, s, w);
        @(negedge clk);
        start = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Send one frame. The first cycle may be a start cycle.
    // When gapped is set, en drops for 2 cycles after bits 3 and 11.
    task automatic send_frame(input logic [0:15] word, input bit with_start,
                              input bit gapped, input string where);
        if (with_start) cycle(1'b1, 1'b0, 1'b0, {where, ".start"});
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, word[i], where);
            if (gapped && (i == 3 || i == 11)) begin
                cycle(1'b0, 1'b0, 1'b1, {where, ".gap"});
                cycle(1'b0, 1'b0, 1'b0, {where, ".gap"});
            end
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        en      = 1'b0;
        f_drv   = 1'b0;
        lb_mode = 1'b0;
        lb_word = '0;
        model_reset();

        // Reset behaviour, then 3 idle cycles with en high.
        async_reset("reset");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, "idle_en");

        // Single frame.
        send_frame(16'hACF1, 1'b1, 1'b0, "frame_acf1");
        cycle(1'b0, 1'b0, 1'b0, "after_acf1");
        check("acf1.w_final", w, 16'hACF1);

        // Gapped frame, then a back-to-back frame started during DONE.
        send_frame(16'hCBE3, 1'b1, 1'b1, "gap_cbe3");
        check("cbe3.w_final", w, 16'hCBE3);
        send_frame(16'hACF1, 1'b1, 1'b0, "b2b_acf1");
        cycle(1'b0, 1'b0, 1'b0, "after_b2b");
        check("b2b.w_final", w, 16'hACF1);

        // Mux loopback: f comes from lb_word[s].
        lb_mode = 1'b1;
        lb_word = 16'hCBE3;
        cycle(1'b1, 1'b1, 1'b0, "lb1.start");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, "lb1");
        check("lb1.w_final", w, 16'hCBE3);
        lb_word = 16'hACF1;
        cycle(1'b1, 1'b1, 1'b0, "lb2.start");
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, "lb2");
        check("lb2.w_final", w, 16'hACF1);
        lb_mode = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, "lb.idle");

        // Restart mid-frame after 7 bits of 1s. start and en are high in the same cycle.
        cycle(1'b1, 1'b0, 1'b0, "rst7.start");
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, "rst7.bits");
        cycle(1'b1, 1'b1, 1'b1, "rst7.restart");
        check("restart.abort", abort, 1'b1);
        check("restart.s", s, 4'd0);
        send_frame(16'h1234, 1'b0, 1'b0, "restart_1234");
        check("restart.w_final", w, 16'h1234);
        cycle(1'b0, 1'b0, 1'b0, "restart.idle");

        // Reset mid-frame at s=9, then a fresh frame.
        cycle(1'b1, 1'b0, 1'b0, "mid.start");
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, "mid.bits");
        check("mid.s_before", s, 4'd9);
        async_reset("mid_reset");
        check("mid_reset.w_cleared", w, 16'h0000);
        send_frame(16'h8001, 1'b1, 1'b0, "frame_8001");
        check("8001.w_final", w, 16'h8001);
        cycle(1'b0, 1'b0, 1'b0, "after_8001");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_demux16.md
Name: serial_demux16

Overview:
- Receive-side counterpart of the 16-to-1 bit-select multiplexer.
- A transmitter walks its 4-bit select across a 16-bit word and emits one bit per strobe. This block captures that serial stream bit by bit into position w[s] and presents the completed 16-bit word with a one-cycle valid pulse.
- Its s output can drive the transmitter mux's select directly, which closes a mux→demux loopback.

Parameters:
- WIDTH, 16, number of bits per frame; must equal 2**SEL_W.
- SEL_W, 4, select/index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  frame start; arms capture and clears the index.
- en  input  1  bit strobe; f is sampled on clk edges where en=1 in SHIFT.
- f  input  1  serial data bit (transmitter mux output).
- s  output  SEL_W  index of the bit to be captured next; usable as the transmitter mux select.
- w  output  [0:WIDTH-1]  last completed word; w[0] is the first bit received.
- valid  output  1  one-cycle pulse when w is updated.
- busy  output  1  high while in SHIFT.
- abort  output  1  one-cycle pulse when start restarts an unfinished frame.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - s=0, w=0, shadow register=0.
  - valid=0, busy=0, abort=0.
  - Reset mid-frame discards the partial frame. w is cleared, not retained.
- States are IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - s=0, busy=0.
  - start=1 → SHIFT next cycle, with s=0 and shadow cleared.
  - en is ignored in IDLE, including when asserted in the same cycle as start. The start cycle captures no bit.
- SHIFT:
  - busy=1.
  - On each edge with en=1: shadow[s] <= f and s <= s+1.
  - en=0 holds s and shadow. There is no timeout.
  - When en=1 and s=WIDTH-1: shadow[WIDTH-1] <= f, w <= complete shadow word (including this bit), s wraps to 0, → DONE.
- DONE:
  - valid=1 for exactly this one cycle. busy=0.
  - start=0 → IDLE.
  - start=1 → SHIFT with s=0 and shadow cleared. This supports back-to-back frames with no dead cycle beyond DONE. abort stays 0.
  - en in DONE is ignored.
- start while in SHIFT, at any s including s=0 with no bits yet:
  - Partial frame discarded. s=0, shadow cleared, remain in SHIFT.
  - abort=1 for one cycle. w and valid are unaffected.
  - start has priority over en in the same cycle; no bit is captured on that cycle.
- w changes only on frame completion or reset. It holds its value across IDLE and SHIFT.
- Latency: valid rises on the clock edge that captures bit WIDTH-1. A minimum frame is 1 start cycle + WIDTH en cycles.
- s never exceeds WIDTH-1. Wrap is WIDTH-1 → 0 only at frame completion.

Test Plan:
- Reset behaviour:
  - Stimulus: drive rst_n=0 asynchronously mid-cycle, with no clock edge.
  - Required: s=0, w=16'h0000, valid=busy=abort=0 immediately.
  - Stimulus: release reset, idle 3 cycles with en=1.
  - Required: s stays 0, busy stays 0, w stays 0.
- Single frame:
  - Stimulus: start pulse, then 16 cycles of en=1 with f = bits of 16'hACF1 in order w[0]..w[15] (1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,1).
  - Required: s counts 0..15. valid pulses exactly once on the 16th capture edge. w=16'hACF1. busy drops in DONE.
- Gapped strobes and back-to-back frames:
  - Stimulus: send 16'hCBE3 with en deasserted for 2 cycles after bits 3 and 11. Hold start=1 during DONE, then send 16'hACF1.
  - Required: first valid with w=16'hCBE3. s holds during the gaps. Second valid with w=16'hACF1. abort never asserts.
- Mux loopback:
  - Stimulus: instantiate the 16-to-1 mux with w=16'hACF1 and select driven by this block's s. Feed the mux output to f with en=1 constant after start.
  - Required: w=16'hACF1 after 16 strobes. Repeat with 16'hCBE3 → w=16'hCBE3.
- Restart mid-frame:
  - Stimulus: after capturing 7 bits of 16'hFFFF, assert start together with en=1, then send 16'h1234.
  - Required: abort pulses one cycle, s=0 on the next cycle, no valid for the aborted frame, previous w retained until w=16'h1234 with a single valid.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 at s=9.
  - Required: all outputs at reset values, with w cleared to 0.
  - Stimulus: new start then 16'h8001.
  - Required: w=16'h8001, valid once.
